// File: rtl/switch_mcu_operand_fetch_pkg.sv
// Shared types and sizes for the MCU operand-fetch slice.
package switch_mcu_pkg;

    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = $clog2(NUM_REGS);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        S1    = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    // True when an enabled write-back targets the given enabled source register.
    function automatic logic reg_hit(
        input logic                  wen,
        input logic [REG_ADDR_W-1:0] waddr,
        input logic [REG_ADDR_W-1:0] raddr,
        input logic                  en
    );
        reg_hit = wen && en && (waddr == raddr);
    endfunction

endpackage

// File: rtl/switch_mcu_operand_fetch_if.sv
// Decoder request, register-file read/write-back and operand handshake bundle.
interface switch_mcu_operand_fetch_if
    import switch_mcu_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = 32
);
    logic                  in_dec_valid;
    logic                  out_dec_ready;
    logic [REG_ADDR_W-1:0] in_rs1;
    logic [REG_ADDR_W-1:0] in_rs2;
    logic                  in_rs1_en;
    logic                  in_rs2_en;
    logic [PAYLOAD_W-1:0]  in_dec_payload;
    logic [REG_ADDR_W-1:0] out_raddr_1;
    logic [REG_ADDR_W-1:0] out_raddr_2;
    logic                  out_ren_1;
    logic                  out_ren_2;
    logic [XLEN-1:0]       in_rdata_1;
    logic [XLEN-1:0]       in_rdata_2;
    logic                  in_wb_wen;
    logic [REG_ADDR_W-1:0] in_wb_waddr;
    logic [XLEN-1:0]       in_wb_wdata;
    logic                  out_op_valid;
    logic                  in_op_ready;
    logic [XLEN-1:0]       out_op1;
    logic [XLEN-1:0]       out_op2;
    logic [PAYLOAD_W-1:0]  out_op_payload;

    modport slave (
        input  in_dec_valid, in_rs1, in_rs2, in_rs1_en, in_rs2_en, in_dec_payload,
        input  in_rdata_1, in_rdata_2, in_wb_wen, in_wb_waddr, in_wb_wdata, in_op_ready,
        output out_dec_ready, out_raddr_1, out_raddr_2, out_ren_1, out_ren_2,
        output out_op_valid, out_op1, out_op2, out_op_payload
    );

    modport master (
        output in_dec_valid, in_rs1, in_rs2, in_rs1_en, in_rs2_en, in_dec_payload,
        output in_rdata_1, in_rdata_2, in_wb_wen, in_wb_waddr, in_wb_wdata, in_op_ready,
        input  out_dec_ready, out_raddr_1, out_raddr_2, out_ren_1, out_ren_2,
        input  out_op_valid, out_op1, out_op2, out_op_payload
    );

endinterface

// File: rtl/switch_mcu_operand_fetch_opnd_slot.sv
// One operand lane: issue-edge forward register, stall hold register, bypass/snoop.
// SWITCH_MCU_X0_ZERO_EN makes x0 read as zero and excludes it from bypass/snoop.
module switch_mcu_opnd_slot
    import switch_mcu_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  issue_i,
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic                  rs_en_i,
    input  logic                  in_s1_i,
    input  logic                  in_hold_i,
    input  logic                  op_ready_i,
    input  logic                  wb_wen_i,
    input  logic [REG_ADDR_W-1:0] wb_waddr_i,
    input  logic [XLEN-1:0]       wb_wdata_i,
    input  logic [XLEN-1:0]       rdata_i,
    output logic                  ren_o,
    output logic [XLEN-1:0]       op_o
);

    logic                  src_en;
    logic                  wb_live;
    logic                  en_q;
    logic [REG_ADDR_W-1:0] rs_q;
    logic                  fwd_flag_q;
    logic [XLEN-1:0]       fwd_q;
    logic [XLEN-1:0]       hold_q;
    logic [XLEN-1:0]       hold_d;
    logic [XLEN-1:0]       s1_val;
    logic [XLEN-1:0]       cur_val;

`ifdef SWITCH_MCU_X0_ZERO_EN
    assign src_en  = rs_en_i && (rs_i != '0);
    assign wb_live = wb_wen_i && (wb_waddr_i != '0);
`else
    assign src_en  = rs_en_i;
    assign wb_live = wb_wen_i;
`endif

    assign ren_o = issue_i && src_en;

    // The read port returns pre-write data, so a same-edge write wins via fwd_q.
    assign s1_val  = !en_q      ? '0    :
                     fwd_flag_q ? fwd_q : rdata_i;
    assign cur_val = in_s1_i ? s1_val : hold_q;
    assign hold_d  = reg_hit(wb_live, wb_waddr_i, rs_q, en_q) ? wb_wdata_i : cur_val;
    assign op_o    = in_s1_i   ? s1_val :
                     in_hold_i ? hold_q : '0;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            en_q       <= 1'b0;
            rs_q       <= '0;
            fwd_flag_q <= 1'b0;
            fwd_q      <= '0;
            hold_q     <= '0;
        end else begin
            if (issue_i) begin
                en_q       <= src_en;
                rs_q       <= rs_i;
                fwd_flag_q <= reg_hit(wb_live, wb_waddr_i, rs_i, src_en);
                fwd_q      <= wb_wdata_i;
            end
            // Stalled: capture out of S1 or keep snooping while in HOLD.
            if ((in_s1_i || in_hold_i) && !op_ready_i) begin
                hold_q <= hold_d;
            end
        end
    end

endmodule

// File: rtl/switch_mcu_operand_fetch.sv
// Operand-fetch stage: issues register-file reads and delivers corrected operands.
// SWITCH_MCU_X0_ZERO_EN (handled in the operand slots) hardwires x0 to zero.
module switch_mcu_operand_fetch
    import switch_mcu_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = 32
)
(
    input  logic                       in_clk,
    input  logic                       in_rst,
    switch_mcu_operand_fetch_if.slave  bus
);

    fetch_state_e         state_q;
    logic                 valid_q;
    logic [PAYLOAD_W-1:0] payload_q;
    logic                 dec_ready;
    logic                 accept;
    logic [XLEN-1:0]      op1;
    logic [XLEN-1:0]      op2;
    logic                 ren1;
    logic                 ren2;

    assign dec_ready = in_rst && (!valid_q || bus.in_op_ready);
    assign accept    = bus.in_dec_valid && dec_ready;

    assign bus.out_dec_ready  = dec_ready;
    assign bus.out_raddr_1    = in_rst ? bus.in_rs1 : '0;
    assign bus.out_raddr_2    = in_rst ? bus.in_rs2 : '0;
    assign bus.out_ren_1      = ren1;
    assign bus.out_ren_2      = ren2;
    assign bus.out_op_valid   = valid_q;
    assign bus.out_op1        = op1;
    assign bus.out_op2        = op2;
    assign bus.out_op_payload = valid_q ? payload_q : '0;

    always_ff @(posedge in_clk) begin
        if (!in_rst) begin
            state_q   <= EMPTY;
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            if (accept) begin
                payload_q <= bus.in_dec_payload;
            end
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_q <= S1;
                        valid_q <= 1'b1;
                    end
                end
                S1, HOLD: begin
                    if (bus.in_op_ready) begin
                        state_q <= accept ? S1 : EMPTY;
                        valid_q <= accept;
                    end else begin
                        state_q <= HOLD;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    switch_mcu_opnd_slot u_slot_1 (
        .clk_i      (in_clk),
        .rst_ni     (in_rst),
        .issue_i    (accept),
        .rs_i       (bus.in_rs1),
        .rs_en_i    (bus.in_rs1_en),
        .in_s1_i    (state_q == S1),
        .in_hold_i  (state_q == HOLD),
        .op_ready_i (bus.in_op_ready),
        .wb_wen_i   (bus.in_wb_wen),
        .wb_waddr_i (bus.in_wb_waddr),
        .wb_wdata_i (bus.in_wb_wdata),
        .rdata_i    (bus.in_rdata_1),
        .ren_o      (ren1),
        .op_o       (op1)
    );

    switch_mcu_opnd_slot u_slot_2 (
        .clk_i      (in_clk),
        .rst_ni     (in_rst),
        .issue_i    (accept),
        .rs_i       (bus.in_rs2),
        .rs_en_i    (bus.in_rs2_en),
        .in_s1_i    (state_q == S1),
        .in_hold_i  (state_q == HOLD),
        .op_ready_i (bus.in_op_ready),
        .wb_wen_i   (bus.in_wb_wen),
        .wb_waddr_i (bus.in_wb_waddr),
        .wb_wdata_i (bus.in_wb_wdata),
        .rdata_i    (bus.in_rdata_2),
        .ren_o      (ren2),
        .op_o       (op2)
    );

endmodule

// File: tb/tb_switch_mcu_operand_fetch.sv
// Bench for switch_mcu_operand_fetch: register-file model, directed cases and a
// randomized run checked every cycle against an architectural register model.
module tb_switch_mcu_operand_fetch;

    localparam int unsigned PW = 32;
`ifdef SWITCH_MCU_X0_ZERO_EN
    localparam bit X0Z = 1'b1;
`else
    localparam bit X0Z = 1'b0;
`endif

    typedef struct {
        logic [4:0]    rs1;
        logic          en1;
        logic [4:0]    rs2;
        logic          en2;
        logic [PW-1:0] pl;
    } req_t;

    logic        clk;
    logic        rst_n;
    int          errors;
    int          checks;
    logic [31:0] rf  [32];
    logic [31:0] mem [32];
    req_t        q[$];

    switch_mcu_operand_fetch_if #(.PAYLOAD_W(PW)) ifc ();

    switch_mcu_operand_fetch #(.PAYLOAD_W(PW)) dut (
        .in_clk (clk),
        .in_rst (rst_n),
        .bus    (ifc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file: registered reads return pre-write contents.
    always @(posedge clk) begin
        if (ifc.in_wb_wen) rf[ifc.in_wb_waddr] <= ifc.in_wb_wdata;
        if (ifc.out_ren_1) ifc.in_rdata_1 <= rf[ifc.out_raddr_1];
        if (ifc.out_ren_2) ifc.in_rdata_2 <= rf[ifc.out_raddr_2];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural value an operand must carry: register contents as of now.
    function automatic logic [31:0] opval(input logic [4:0] rs, input logic en);
        if (!en) return 32'h0;
        if (X0Z && rs == 5'd0) return 32'h0;
        return mem[rs];
    endfunction

    initial begin : model
        req_t h;
        logic v;
        logic rdy_exp;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            v = (q.size() != 0);
            rdy_exp = rst_n && (!v || ifc.in_op_ready);
            check("op_valid", 64'(ifc.out_op_valid), 64'(v));
            if (v) begin
                h = q[0];
                check("op1", 64'(ifc.out_op1), 64'(opval(h.rs1, h.en1)));
                check("op2", 64'(ifc.out_op2), 64'(opval(h.rs2, h.en2)));
                check("payload", 64'(ifc.out_op_payload), 64'(h.pl));
            end else begin
                check("op1_idle", 64'(ifc.out_op1), 64'h0);
                check("op2_idle", 64'(ifc.out_op2), 64'h0);
                check("payload_idle", 64'(ifc.out_op_payload), 64'h0);
            end
            check("dec_ready", 64'(ifc.out_dec_ready), 64'(rdy_exp));
            check("raddr_1", 64'(ifc.out_raddr_1), rst_n ? 64'(ifc.in_rs1) : 64'h0);
            check("raddr_2", 64'(ifc.out_raddr_2), rst_n ? 64'(ifc.in_rs2) : 64'h0);
            check("ren_1", 64'(ifc.out_ren_1), 64'(ifc.in_dec_valid && rdy_exp && ifc.in_rs1_en
                                                   && !(X0Z && ifc.in_rs1 == 5'd0)));
            check("ren_2", 64'(ifc.out_ren_2), 64'(ifc.in_dec_valid && rdy_exp && ifc.in_rs2_en
                                                   && !(X0Z && ifc.in_rs2 == 5'd0)));
            // Effect of the coming edge.
            if (!rst_n) begin
                q.delete();
            end else begin
                if (v && ifc.in_op_ready) void'(q.pop_front());
                if (ifc.in_dec_valid && rdy_exp)
                    q.push_back('{ifc.in_rs1, ifc.in_rs1_en, ifc.in_rs2, ifc.in_rs2_en, ifc.in_dec_payload});
            end
            if (ifc.in_wb_wen) mem[ifc.in_wb_waddr] = ifc.in_wb_wdata;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic dv, input logic [4:0] r1, input logic e1,
                       input logic [4:0] r2, input logic e2, input logic [PW-1:0] pl,
                       input logic rdy);
        ifc.in_dec_valid   = dv;
        ifc.in_rs1         = r1;
        ifc.in_rs1_en      = e1;
        ifc.in_rs2         = r2;
        ifc.in_rs2_en      = e2;
        ifc.in_dec_payload = pl;
        ifc.in_op_ready    = rdy;
    endtask

    task automatic wb(input logic w, input logic [4:0] a, input logic [31:0] d);
        ifc.in_wb_wen   = w;
        ifc.in_wb_waddr = a;
        ifc.in_wb_wdata = d;
    endtask

    initial begin : stim
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        req(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, '0, 1'b1);
        wb(1'b0, 5'd0, 32'h0);
        step();

        // Fill every register while held in reset.
        for (int i = 0; i < 32; i++) begin
            wb(1'b1, 5'(i), $urandom);
            req(1'b1, 5'(i), 1'b1, 5'(i), 1'b1, '1, 1'b1);
            step();
            check("rst_valid", 64'(ifc.out_op_valid), 64'h0);
        end
        req(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, '0, 1'b1);
        rst_n = 1'b1;
        wb(1'b1, 5'd3, 32'h11); step();
        wb(1'b1, 5'd4, 32'h22); step();
        wb(1'b1, 5'd5, 32'h77); step();
        wb(1'b0, 5'd0, 32'h0);

        // Single request.
        req(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 32'hA1, 1'b1); step();
        req(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, '0, 1'b1);
        check("t1_valid", 64'(ifc.out_op_valid), 64'h1);
        check("t1_op1", 64'(ifc.out_op1), 64'h11);
        check("t1_op2", 64'(ifc.out_op2), 64'h22);
        check("t1_pl", 64'(ifc.out_op_payload), 64'hA1);
        step();
        check("t1_done", 64'(ifc.out_op_valid), 64'h0);

        // Issue-edge bypass.
        req(1'b1, 5'd5, 1'b1, 5'd4, 1'b1, 32'hA2, 1'b1);
        wb(1'b1, 5'd5, 32'hDEAD); step();
        req(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, '0, 1'b1);
        wb(1'b0, 5'd0, 32'h0);
        check("t2_rdata_stale", 64'(ifc.in_rdata_1), 64'h77);
        check("t2_op1", 64'(ifc.out_op1), 64'hDEAD);
        step();

        // Stall with capture then snoop.
        req(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 32'hB3, 1'b0); step();
        req(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, '0, 1'b0);
        wb(1'b1, 5'd4, 32'hBEEF);
        check("t3_ready0", 64'(ifc.out_dec_ready), 64'h0);
        step();
        wb(1'b1, 5'd4, 32'hCAFE);
        check("t3_capture", 64'(ifc.out_op2), 64'hBEEF);
        check("t3_ready1", 64'(ifc.out_dec_ready), 64'h0);
        step();
        wb(1'b0, 5'd0, 32'h0);
        check("t3_snoop", 64'(ifc.out_op2), 64'hCAFE);
        check("t3_ready2", 64'(ifc.out_dec_ready), 64'h0);
        step();
        ifc.in_op_ready = 1'b1;
        #1;
        check("t3_op2", 64'(ifc.out_op2), 64'hCAFE);
        check("t3_pl", 64'(ifc.out_op_payload), 64'hB3);
        check("t3_ready3", 64'(ifc.out_dec_ready), 64'h1);
        step();
        check("t3_done", 64'(ifc.out_op_valid), 64'h0);

        // Back-to-back.
        for (int i = 0; i < 4; i++) begin
            req(1'b1, 5'(6 + i), 1'b1, 5'(10 + i), 1'b1, 32'(32'hC0 + i), 1'b1);
            step();
            check("t4_valid", 64'(ifc.out_op_valid), 64'h1);
            check("t4_pl", 64'(ifc.out_op_payload), 64'(32'hC0 + i));
        end
        req(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, '0, 1'b1); step();
        check("t4_done", 64'(ifc.out_op_valid), 64'h0);

        // x0 handling and disabled operand.
        req(1'b1, 5'd0, 1'b1, 5'd9, 1'b0, 32'hD5, 1'b1);
        wb(1'b1, 5'd0, 32'h5);
        #1;
        check("t5_ren1", 64'(ifc.out_ren_1), X0Z ? 64'h0 : 64'h1);
        check("t5_ren2", 64'(ifc.out_ren_2), 64'h0);
        step();
        req(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, '0, 1'b1);
        wb(1'b0, 5'd0, 32'h0);
        check("t5_op1", 64'(ifc.out_op1), X0Z ? 64'h0 : 64'h5);
        check("t5_op2", 64'(ifc.out_op2), 64'h0);
        step();

        // Reset while holding.
        req(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 32'hE6, 1'b0); step();
        req(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, '0, 1'b0); step();
        check("t6_held", 64'(ifc.out_op_valid), 64'h1);
        rst_n = 1'b0; step();
        check("t6_valid", 64'(ifc.out_op_valid), 64'h0);
        check("t6_op1", 64'(ifc.out_op1), 64'h0);
        check("t6_op2", 64'(ifc.out_op2), 64'h0);
        check("t6_pl", 64'(ifc.out_op_payload), 64'h0);
        check("t6_ready", 64'(ifc.out_dec_ready), 64'h0);
        rst_n = 1'b1;
        req(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 32'hF7, 1'b1); step();
        req(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, '0, 1'b1);
        check("t6_after_op1", 64'(ifc.out_op1), 64'h11);
        check("t6_after_op2", 64'(ifc.out_op2), 64'hCAFE);
        check("t6_after_pl", 64'(ifc.out_op_payload), 64'hF7);
        step();

        // Randomized traffic on a narrow address range to provoke hits.
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            req(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), ($urandom_range(0, 7) != 0),
                5'($urandom_range(0, 7)), ($urandom_range(0, 7) != 0), $urandom,
                ($urandom_range(0, 2) != 0));
            wb(($urandom_range(0, 1) != 0), 5'($urandom_range(0, 7)), $urandom);
            step();
        end
        rst_n = 1'b1;
        req(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, '0, 1'b1);
        wb(1'b0, 5'd0, 32'h0);
        step();
        step();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/switch_mcu_operand_fetch.md
# switch_mcu_operand_fetch

Operand-fetch stage that drives the two registered read ports of the MCU register file on behalf of the decoder, and presents a one-cycle-latency operand pair downstream with a valid/ready handshake. Register-file reads return pre-write data when a write lands on the same edge, so the block corrects stale results from the write-back port. It also snoops that port while operands are stalled, so that delivered operands always reflect every write sampled before the edge at which downstream accepts them.

## Interface
- PAYLOAD_W, 32, width of the opaque decoded-instruction payload carried alongside operands
- in_clk  in  1  clock, all state on rising edge
- in_rst  in  1  reset, synchronous, active-low
- in_dec_valid  in  1  decoder request valid
- out_dec_ready  out  1  block accepts request this cycle
- in_rs1 / in_rs2  in  5  source register addresses
- in_rs1_en / in_rs2_en  in  1  source used; if 0, that operand is 0
- in_dec_payload  in  PAYLOAD_W  passed through unchanged
- out_raddr_1 / out_raddr_2  out  5  register-file read addresses
- out_ren_1 / out_ren_2  out  1  register-file read enables
- in_rdata_1 / in_rdata_2  in  32  register-file read data, registered (valid the cycle after ren)
- in_wb_wen  in  1  write-back enable (same signal as register-file write port)
- in_wb_waddr  in  5  write-back address
- in_wb_wdata  in  32  write-back data
- out_op_valid  out  1  operands valid
- in_op_ready  in  1  downstream accepts
- out_op1 / out_op2  out  32  operands
- out_op_payload  out  PAYLOAD_W  payload of delivered request

## Operation
- Two internal slots: S1 (read in flight; data arrives from register file this cycle) and HOLD (operands captured, downstream stalled). S1 and HOLD are never both valid.
- States: EMPTY, S1, HOLD.
  - EMPTY→S1 on accept.
  - S1→EMPTY if accepted downstream with no new request.
  - S1→S1 if accepted downstream and a new request is accepted.
  - S1→HOLD if not accepted.
  - HOLD→S1 or EMPTY on downstream accept, depending on whether a new request is accepted.
- out_dec_ready = !out_op_valid | in_op_ready. A request is accepted when in_dec_valid & out_dec_ready.
- Issue: out_raddr_x = in_rsx (combinational). out_ren_x = accept & in_rsx_en.
- Issue-edge bypass:
  - At the accept edge, if in_wb_wen & in_wb_waddr == in_rsx & in_rsx_en, capture in_wb_wdata into a per-operand forward register and set its flag.
  - In S1, out_opx = flag ? forward register : in_rdata_x.
- S1→HOLD capture: the operand as above, then overwritten by in_wb_wdata if a matching write is sampled on that same edge.
- HOLD snoop: each edge in HOLD, a matching write (enabled operand only) overwrites the held operand.
- Disabled operand: ren low, operand is 0, never bypassed or snooped.
- Payload is registered at accept and held until delivered.

## Timing
- Latency: request accepted at edge N produces out_op_valid in cycle N+1. Throughput is 1 per cycle while in_op_ready = 1.
- In S1, the current-cycle write is not combinationally bypassed. It is applied only if the request moves to HOLD.
- Reset (in_rst = 0 sampled at an edge):
  - Clears S1, HOLD and forward flags.
  - Outputs: out_op_valid = 0; out_op1, out_op2 and out_op_payload = 0.
  - While in_rst = 0: out_dec_ready = 0, out_ren_x = 0, out_raddr_x = 0.
  - Mid-operation reset discards in-flight and held requests without delivery.
- Address wrap: addresses are 5-bit, compared on all 5 bits.

## Configuration
- SWITCH_MCU_X0_ZERO_EN defined:
  - Source address 0 yields operand 0 with ren low.
  - Writes to address 0 are never bypassed or snooped.
- Undefined: address 0 behaves as an ordinary register, including bypass and snoop.

## Structure
- Shared package switch_mcu_pkg: XLEN = 32, REG_ADDR_W = 5, NUM_REGS = 32; fetch state enum (EMPTY, S1, HOLD).
- One sub-module switch_mcu_opnd_slot, instantiated twice (one per operand). It holds the forward register/flag, the HOLD register, and the bypass/snoop compare and mux.
- The state machine, handshake and payload register live in the top module.

## Test plan
- Single request, rs1 = 3 (holds 0x11), rs2 = 4 (holds 0x22), in_op_ready = 1 → cycle N+1: out_op1 = 0x11, out_op2 = 0x22, valid for one cycle.
- Issue rs1 = 5 on the same edge as a write of 0xDEAD to x5 → out_op1 = 0xDEAD, although in_rdata_1 shows the old value.
- in_op_ready = 0 for 3 cycles; write x4 = 0xBEEF on the first stall edge, then x4 = 0xCAFE on the next → delivered out_op2 = 0xCAFE. out_dec_ready is 0 throughout the stall.
- Back-to-back requests on 4 consecutive cycles with ready = 1 → 4 consecutive valid outputs in order, with payloads matching.
- rs1 = 0 with a write of 0x5 to x0 at issue → out_op1 = 0 when SWITCH_MCU_X0_ZERO_EN is defined, and 0x5 when it is undefined. Separately, rs2_en = 0 → out_op2 = 0 and out_ren_2 = 0.
- Assert in_rst = 0 while in HOLD → next cycle out_op_valid = 0 and operands = 0. After release, a new request completes normally.
